// File: rtl/fetch_unit.sv
// Decoupled instruction fetch: credit-limited pipelined memory port feeding a DEPTH-entry
// prefetch buffer; a redirect flushes the buffer and drops every response still in flight.
module fetch_unit #(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] instr_pc,
  output logic [XLEN-1:0] instr_incpc
);
  localparam int unsigned     PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned     CW      = $clog2(DEPTH + 1);
  localparam logic [CW:0]     CREDITS = (CW+1)'(DEPTH);
  localparam logic [XLEN-1:0] STEP    = XLEN'(4);

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
  logic [CW-1:0]   out_cnt_q, out_cnt_d;
  logic [CW-1:0]   kill_cnt_q, kill_cnt_d;
  logic [CW-1:0]   occ_q, occ_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [XLEN-1:0] buf_pc_q    [DEPTH];
  logic [XLEN-1:0] buf_pc_d    [DEPTH];
  logic [XLEN-1:0] buf_instr_q [DEPTH];
  logic [XLEN-1:0] buf_instr_d [DEPTH];

  logic [CW:0]     credits_used;
  logic [XLEN-1:0] redirect_tgt;
  logic            req_fire;
  logic            rsp_live;
  logic            push;
  logic            pop;

  // Killed requests still hold a credit until their response returns.
  assign credits_used   = {1'b0, occ_q} + {1'b0, out_cnt_q};
  assign imem_req_valid = rst && !redirect_valid && (credits_used < CREDITS);
  assign imem_addr      = fetch_pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign rsp_live       = imem_rsp_valid && (out_cnt_q != '0);
  assign push           = rsp_live && (kill_cnt_q == '0) && !redirect_valid;
  assign instr_valid    = (occ_q != '0) && !redirect_valid;
  assign pop            = instr_valid && instr_ready;
  assign redirect_tgt   = redirect_pc & ~XLEN'(3);

  assign instr       = buf_instr_q[rd_ptr_q];
  assign instr_pc    = buf_pc_q[rd_ptr_q];
  assign instr_incpc = buf_pc_q[rd_ptr_q] + STEP;

  always_comb begin
    fetch_pc_d  = fetch_pc_q;
    rsp_pc_d    = rsp_pc_q;
    kill_cnt_d  = kill_cnt_q;
    occ_d       = occ_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    buf_pc_d    = buf_pc_q;
    buf_instr_d = buf_instr_q;
    out_cnt_d   = out_cnt_q + CW'(req_fire) - CW'(rsp_live);

    if (redirect_valid) begin
      // No issue this cycle, so out_cnt_d is exactly what is left in flight.
      fetch_pc_d = redirect_tgt;
      rsp_pc_d   = redirect_tgt;
      kill_cnt_d = out_cnt_d;
      occ_d      = '0;
      rd_ptr_d   = wr_ptr_q;
    end else begin
      if (req_fire) begin
        fetch_pc_d = fetch_pc_q + STEP;
      end
      if (rsp_live && (kill_cnt_q != '0)) begin
        kill_cnt_d = kill_cnt_q - CW'(1);
      end
      if (push) begin
        buf_pc_d[wr_ptr_q]    = rsp_pc_q;
        buf_instr_d[wr_ptr_q] = imem_rsp_data;
        wr_ptr_d              = wr_ptr_q + PW'(1);
        rsp_pc_d              = rsp_pc_q + STEP;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      occ_d = occ_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc_q <= RESET_PC;
      rsp_pc_q   <= RESET_PC;
      out_cnt_q  <= '0;
      kill_cnt_q <= '0;
      occ_q      <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        buf_pc_q[i]    <= '0;
        buf_instr_q[i] <= '0;
      end
    end else begin
      fetch_pc_q  <= fetch_pc_d;
      rsp_pc_q    <= rsp_pc_d;
      out_cnt_q   <= out_cnt_d;
      kill_cnt_q  <= kill_cnt_d;
      occ_q       <= occ_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      buf_pc_q    <= buf_pc_d;
      buf_instr_q <= buf_instr_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: in-order memory model with fixed or random latency,
// PC-sequence scoreboard on every decode pop, plus a cycle-by-cycle vector table.
`timescale 1ns/1ps
module tb_fetch_unit;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] MAGIC    = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [31:0] instr_incpc;

  fetch_unit #(.XLEN(32), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk           (clk),
    .rst           (rst),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_addr     (imem_addr),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data (imem_rsp_data),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .instr         (instr),
    .instr_pc      (instr_pc),
    .instr_incpc   (instr_incpc)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  mreq_t       mq[$];
  int          edge_no = 0;
  int          last_due = 0;
  int          lat = 1;
  bit          rand_lat = 1'b0;
  logic [31:0] exp_pc = RESET_PC;
  int          rsp_n = 0;
  int          pop_n = 0;
  int          fired_n = 0;

  // A response with nothing outstanding would be a memory-side protocol violation.
  assert property (@(posedge clk) disable iff (!rst) !(imem_rsp_valid && (dut.out_cnt_q == '0)))
    else begin
      errors++;
      $display("FAIL assert_rsp_without_request at edge %0d", edge_no);
    end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called just after the falling edge with this cycle's inputs applied.
  task automatic cycle();
    mreq_t r;
    int    l;
    if (rst) begin
      if (imem_req_valid && imem_req_ready) begin
        l = rand_lat ? int'($urandom_range(1, 5)) : lat;
        r.addr = imem_addr;
        r.due  = edge_no + l;
        if (r.due < last_due) r.due = last_due;
        last_due = r.due;
        mq.push_back(r);
        fired_n++;
      end
      if (redirect_valid) exp_pc = redirect_pc & ~32'h3;
      if (instr_valid && instr_ready) begin
        chk("sb_pc", instr_pc, exp_pc);
        chk("sb_instr", instr, exp_pc ^ MAGIC);
        chk("sb_incpc", instr_incpc, exp_pc + 32'd4);
        exp_pc = exp_pc + 32'd4;
        pop_n++;
      end
    end
    imem_rsp_valid = 1'b0;
    if (rst && (mq.size() > 0) && (mq[0].due <= edge_no)) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mq[0].addr ^ MAGIC;
      void'(mq.pop_front());
      rsp_n++;
    end
    @(posedge clk);
    edge_no++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst            = 1'b0;
    imem_rsp_valid = 1'b0;
    instr_ready    = 1'b0;
    imem_req_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    mq.delete();
    last_due = 0;
    exp_pc   = RESET_PC;
    rsp_n    = 0;
    pop_n    = 0;
    fired_n  = 0;
    #1;
    chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("rst_instr_valid", 32'(instr_valid), 32'd0);
    chk("rst_addr", imem_addr, RESET_PC);
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  typedef struct {
    logic        ird;
    logic        mrdy;
    logic        rv;
    logic [31:0] addr;
    logic        iv;
    logic [31:0] ipc;
  } vec_t;

  vec_t tbl[13];
  bit   seen;

  initial begin
    // Latency 1 stream, one stall on the memory side and one on decode.
    tbl[0]  = '{1'b1, 1'b1, 1'b1, 32'h00, 1'b0, 32'h00};
    tbl[1]  = '{1'b1, 1'b1, 1'b1, 32'h04, 1'b0, 32'h00};
    tbl[2]  = '{1'b1, 1'b1, 1'b1, 32'h08, 1'b1, 32'h00};
    tbl[3]  = '{1'b1, 1'b1, 1'b1, 32'h0C, 1'b1, 32'h04};
    tbl[4]  = '{1'b1, 1'b1, 1'b1, 32'h10, 1'b1, 32'h08};
    tbl[5]  = '{1'b1, 1'b1, 1'b1, 32'h14, 1'b1, 32'h0C};
    tbl[6]  = '{1'b1, 1'b0, 1'b1, 32'h18, 1'b1, 32'h10};
    tbl[7]  = '{1'b1, 1'b1, 1'b1, 32'h18, 1'b1, 32'h14};
    tbl[8]  = '{1'b1, 1'b1, 1'b1, 32'h1C, 1'b0, 32'h00};
    tbl[9]  = '{1'b1, 1'b1, 1'b1, 32'h20, 1'b1, 32'h18};
    tbl[10] = '{1'b0, 1'b1, 1'b1, 32'h24, 1'b1, 32'h1C};
    tbl[11] = '{1'b1, 1'b1, 1'b1, 32'h28, 1'b1, 32'h1C};
    tbl[12] = '{1'b1, 1'b1, 1'b1, 32'h2C, 1'b1, 32'h20};

    #2;
    // Test 1: table-driven stream at latency 1.
    do_reset();
    lat = 1;
    for (int i = 0; i < 13; i++) begin
      instr_ready    = tbl[i].ird;
      imem_req_ready = tbl[i].mrdy;
      #1;
      chk($sformatf("t1_req_valid[%0d]", i), 32'(imem_req_valid), 32'(tbl[i].rv));
      chk($sformatf("t1_addr[%0d]", i), imem_addr, tbl[i].addr);
      chk($sformatf("t1_instr_valid[%0d]", i), 32'(instr_valid), 32'(tbl[i].iv));
      if (tbl[i].iv) chk($sformatf("t1_instr_pc[%0d]", i), instr_pc, tbl[i].ipc);
      cycle();
    end

    // Test 2: decode stalled, buffer fills, then drains in order and fetch resumes.
    do_reset();
    lat = 2;
    imem_req_ready = 1'b1;
    repeat (20) begin
      #1;
      cycle();
    end
    #1;
    chk("t2_full_instr_valid", 32'(instr_valid), 32'd1);
    chk("t2_full_head_pc", instr_pc, 32'h0);
    chk("t2_full_req_valid", 32'(imem_req_valid), 32'd0);
    instr_ready = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin
      #1;
      if (imem_req_valid) begin
        chk("t2_resume_addr", imem_addr, 32'h10);
        seen = 1'b1;
      end
      cycle();
    end
    chk("t2_resume_seen", 32'(seen), 32'd1);
    repeat (20) begin
      #1;
      cycle();
    end
    chk("t2_enough_pops", 32'(pop_n >= 10), 32'd1);

    // Test 3: redirect with 0x20 and 0x24 in flight.
    do_reset();
    lat = 2;
    instr_ready    = 1'b1;
    imem_req_ready = 1'b1;
    repeat (10) begin
      #1;
      cycle();
    end
    #1;
    chk("t3_pre_addr", imem_addr, 32'h28);
    chk("t3_pre_head_pc", instr_pc, 32'h1C);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    #1;
    chk("t3_redir_instr_valid", 32'(instr_valid), 32'd0);
    chk("t3_redir_req_valid", 32'(imem_req_valid), 32'd0);
    cycle();
    redirect_valid = 1'b0;
    #1;
    chk("t3_post_addr", imem_addr, 32'h100);
    chk("t3_post_req_valid", 32'(imem_req_valid), 32'd1);
    chk("t3_post_instr_valid", 32'(instr_valid), 32'd0);
    cycle();
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      #1;
      if (instr_valid) begin
        chk("t3_first_pc", instr_pc, 32'h100);
        seen = 1'b1;
      end
      cycle();
    end
    chk("t3_first_seen", 32'(seen), 32'd1);

    // Test 4: redirect on a cycle with a live response and a pending pop, unaligned target.
    repeat (8) begin
      #1;
      cycle();
    end
    #1;
    chk("t4_pending_pop", 32'(instr_valid), 32'd1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h203;
    #1;
    chk("t4_redir_instr_valid", 32'(instr_valid), 32'd0);
    cycle();
    redirect_valid = 1'b0;
    #1;
    chk("t4_post_addr", imem_addr, 32'h200);
    cycle();
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      #1;
      if (instr_valid) begin
        chk("t4_first_pc", instr_pc, 32'h200);
        seen = 1'b1;
      end
      cycle();
    end
    chk("t4_first_seen", 32'(seen), 32'd1);

    // Test 5: random memory readiness, decode readiness and latency 1..5.
    do_reset();
    rand_lat = 1'b1;
    for (int c = 0; c < 600; c++) begin
      instr_ready    = 1'($urandom_range(0, 1));
      imem_req_ready = 1'($urandom_range(0, 1));
      #1;
      chk("t5_credit", 32'((mq.size() + rsp_n - pop_n) <= DEPTH), 32'd1);
      cycle();
    end
    imem_req_ready = 1'b0;
    instr_ready    = 1'b1;
    repeat (20) begin
      #1;
      cycle();
    end
    chk("t5_all_delivered", 32'(pop_n), 32'(fired_n));
    chk("t5_progress", 32'(pop_n >= 50), 32'd1);
    rand_lat = 1'b0;

    // Test 6: asynchronous reset between clock edges with three entries buffered.
    do_reset();
    lat = 1;
    imem_req_ready = 1'b1;
    repeat (4) begin
      #1;
      cycle();
    end
    #1;
    chk("t6_pre_instr_valid", 32'(instr_valid), 32'd1);
    chk("t6_pre_head_pc", instr_pc, 32'h0);
    #2;
    do_reset();
    instr_ready    = 1'b1;
    imem_req_ready = 1'b1;
    #1;
    chk("t6_restart_req_valid", 32'(imem_req_valid), 32'd1);
    chk("t6_restart_addr", imem_addr, RESET_PC);
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      if (c != 0) #1;
      if (instr_valid) begin
        chk("t6_first_pc", instr_pc, RESET_PC);
        seen = 1'b1;
      end
      cycle();
    end
    chk("t6_first_seen", 32'(seen), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
